// File: rtl/dac_stream_driver.sv
// ----------------------------------------------------------------------------
// dac_stream_driver
//
// Streams multi-channel frames from a small FIFO onto a single time-multiplexed
// DAC. Each DAC slot lasts DIV clock cycles. DAC_CLK is high for the second
// half of every slot, so the DAC word is stable for DIV/2 cycles before its
// latching rising edge. Every CHANNELS slots a new frame is popped from the
// FIFO. If the FIFO is empty at that point, the previous frame repeats and the
// sticky underrun flag LED1 is set.
//
// Ports
//   CLK           in   sole clock, rising edge
//   BUT1          in   asynchronous active-low reset
//   run           in   1 = slot timing advances, 0 = paused (FIFO push continues)
//   in_valid      in   frame offered on in_data
//   in_ready      out  FIFO can accept a frame (level != DEPTH)
//   in_data       in   frame; channel k in bits [k*WIDTH +: WIDTH]
//   underrun_clr  in   clears LED1 (an underrun on the same edge wins)
//   DAC           out  registered DAC word
//   DAC_CLK       out  registered DAC latch clock
//   DAC_SEL       out  channel index of the current DAC word
//   LED1          out  sticky underrun flag
//   fifo_level    out  frames held in the FIFO, 0..DEPTH
// ----------------------------------------------------------------------------
module dac_stream_driver #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 2,
  parameter int DEPTH    = 8,
  parameter int DIV      = 4,
  localparam int SEL_W   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
  localparam int LVL_W   = $clog2(DEPTH) + 1
) (
  input  logic                      CLK,
  input  logic                      BUT1,
  input  logic                      run,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic                      underrun_clr,
  output logic [WIDTH-1:0]          DAC,
  output logic                      DAC_CLK,
  output logic [SEL_W-1:0]          DAC_SEL,
  output logic                      LED1,
  output logic [LVL_W-1:0]          fifo_level
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int DIV_W = $clog2(DIV);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
  localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(DIV / 2);
  localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(CHANNELS - 1);
  localparam logic [WIDTH-1:0] MIDSCALE = WIDTH'(1) << (WIDTH - 1);
  localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(DEPTH);

  // --------------------------------------------------------------------------
  // Slot timing
  // --------------------------------------------------------------------------
  logic [DIV_W-1:0] div_cnt;
  logic [DIV_W-1:0] div_next;
  logic             slot_end;
  logic [SEL_W-1:0] sel_next;
  logic             frame_end;

  assign slot_end  = run && (div_cnt == DIV_LAST);
  assign div_next  = !run ? div_cnt : (slot_end ? '0 : div_cnt + 1'b1);
  assign sel_next  = (DAC_SEL == SEL_LAST) ? '0 : DAC_SEL + 1'b1;
  assign frame_end = slot_end && (sel_next == '0);

  // --------------------------------------------------------------------------
  // Frame FIFO
  // --------------------------------------------------------------------------
  logic [CHANNELS*WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0]          wr_ptr;
  logic [PTR_W-1:0]          rd_ptr;
  logic [CHANNELS*WIDTH-1:0] pop_frame;
  logic                      fifo_empty;
  logic                      push;
  logic                      pop;
  logic                      underrun;

  // in_ready depends only on the registered level, so a pop on the same edge
  // never lets a push into a full FIFO.
  assign in_ready   = (fifo_level != LVL_FULL);
  assign fifo_empty = (fifo_level == '0);
  assign push       = in_valid && in_ready;
  // A push arriving on the frame-boundary edge is not visible yet (the level
  // is still zero), so that boundary is an underrun and the frame waits.
  assign pop        = frame_end && !fifo_empty;
  assign underrun   = frame_end && fifo_empty;
  assign pop_frame  = mem[rd_ptr];

  // NOTE: the storage array has no reset; only pointers and level do, so an
  // empty FIFO never exposes its stale contents and the array maps to RAM.
  always_ff @(posedge CLK) begin
    if (push) begin
      mem[wr_ptr] <= in_data;
    end
  end

  // NOTE: every clocked block uses non-blocking assignments so that all
  // registers sample pre-edge values regardless of statement order.
  always_ff @(posedge CLK or negedge BUT1) begin
    if (!BUT1) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
    end else begin
      // Pointers are PTR_W bits wide with DEPTH a power of two: natural wrap.
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_level <= fifo_level + 1'b1;
        2'b01:   fifo_level <= fifo_level - 1'b1;
        default: fifo_level <= fifo_level;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // DAC output path
  // --------------------------------------------------------------------------
  logic [CHANNELS*WIDTH-1:0] frame;

  always_ff @(posedge CLK or negedge BUT1) begin
    if (!BUT1) begin
      div_cnt <= '0;
      DAC_CLK <= 1'b0;
      // Starting on the last channel makes the first slot boundary after
      // reset wrap to channel 0 and fetch a frame.
      DAC_SEL <= SEL_LAST;
      DAC     <= MIDSCALE;
      frame   <= {CHANNELS{MIDSCALE}};
      LED1    <= 1'b0;
    end else begin
      div_cnt <= div_next;
      // Registered from the next count so DAC_CLK tracks div_cnt exactly.
      DAC_CLK <= (div_next >= DIV_HALF);
      if (slot_end) begin
        DAC_SEL <= sel_next;
        if (pop) begin
          // Freshly popped frame drives channel 0 on the same edge.
          frame <= pop_frame;
          DAC   <= pop_frame[WIDTH-1:0];
        end else begin
          DAC <= frame[sel_next*WIDTH +: WIDTH];
        end
      end
      if (underrun) begin
        LED1 <= 1'b1;
      end else if (run && underrun_clr) begin
        LED1 <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_dac_stream_driver.sv
// ----------------------------------------------------------------------------
// tb_dac_stream_driver
//
// Directed bench for dac_stream_driver (WIDTH=8, CHANNELS=2, DEPTH=4, DIV=4).
// A behavioural model (frame queue plus a count of running cycles) predicts
// every output and is compared on each falling clock edge; directed sections
// add hand-computed literal expectations at chosen cycles.
// ----------------------------------------------------------------------------
module tb_dac_stream_driver;

  localparam int W  = 8;
  localparam int CH = 2;
  localparam int D  = 4;
  localparam int DV = 4;
  localparam logic [W-1:0] MID = 8'h80;

  logic          CLK;
  logic          BUT1;
  logic          run;
  logic          in_valid;
  logic          in_ready;
  logic [CH*W-1:0] in_data;
  logic          underrun_clr;
  logic [W-1:0]  DAC;
  logic          DAC_CLK;
  logic [0:0]    DAC_SEL;
  logic          LED1;
  logic [2:0]    fifo_level;

  dac_stream_driver #(
    .WIDTH    (W),
    .CHANNELS (CH),
    .DEPTH    (D),
    .DIV      (DV)
  ) dut (
    .CLK          (CLK),
    .BUT1         (BUT1),
    .run          (run),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .underrun_clr (underrun_clr),
    .DAC          (DAC),
    .DAC_CLK      (DAC_CLK),
    .DAC_SEL      (DAC_SEL),
    .LED1         (LED1),
    .fifo_level   (fifo_level)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // --------------------------------------------------------------------------
  // Behavioural model: FIFO as a queue, slot position derived from the number
  // of running cycles since reset, current channel from a slot counter.
  // --------------------------------------------------------------------------
  logic [CH*W-1:0] m_q[$];
  logic [CH*W-1:0] m_frame;
  int              m_ticks;
  int              m_slot;
  logic            m_led;
  logic [W-1:0]    m_dac;
  bit              m_push;
  bit              m_set;

  initial begin
    forever begin
      @(posedge CLK or negedge BUT1);
      if (!BUT1) begin
        m_q.delete();
        m_frame = {CH{MID}};
        m_ticks = 0;
        m_slot  = CH - 1;
        m_led   = 1'b0;
        m_dac   = MID;
      end else begin
        m_push = in_valid && (m_q.size() < D);
        m_set  = 1'b0;
        if (run) begin
          if ((m_ticks % DV) == DV - 1) begin
            m_slot = (m_slot + 1) % CH;
            if (m_slot == 0) begin
              if (m_q.size() > 0) m_frame = m_q.pop_front();
              else m_set = 1'b1;
            end
            m_dac = m_frame[m_slot*W +: W];
          end
          m_ticks++;
        end
        if (m_set) m_led = 1'b1;
        else if (run && underrun_clr) m_led = 1'b0;
        if (m_push) m_q.push_back(in_data);
      end
    end
  end

  always @(negedge CLK) begin
    if (BUT1) begin
      check("model_dac",      32'(DAC),        32'(m_dac));
      check("model_sel",      32'(DAC_SEL),    32'(m_slot));
      check("model_dac_clk",  32'(DAC_CLK),    32'((m_ticks % DV) >= DV / 2));
      check("model_led1",     32'(LED1),       32'(m_led));
      check("model_level",    32'(fifo_level), 32'(m_q.size()));
      check("model_in_ready", 32'(in_ready),   32'(m_q.size() < D));
    end
  end

  // --------------------------------------------------------------------------
  // Stimulus helpers: inputs change 1 time unit after the rising edge.
  // --------------------------------------------------------------------------
  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic do_reset();
    BUT1 = 1'b0;
    run = 1'b0;
    in_valid = 1'b0;
    underrun_clr = 1'b0;
    in_data = '0;
    cyc(2);
    BUT1 = 1'b1;
  endtask

  logic [W-1:0] stream_vals [4];
  logic [W-1:0] exp_dac;

  initial begin
    stream_vals = '{8'h10, 8'h20, 8'h30, 8'h40};
    BUT1 = 1'b0;
    run = 1'b0;
    in_valid = 1'b0;
    underrun_clr = 1'b0;
    in_data = '0;

    // ---------------- streaming ----------------
    do_reset();
    check("reset_dac", 32'(DAC), 32'h80);
    check("reset_sel", 32'(DAC_SEL), 32'd1);
    in_valid = 1'b1;
    in_data  = {8'h20, 8'h10};
    cyc(1);
    in_data  = {8'h40, 8'h30};
    cyc(1);
    in_valid = 1'b0;
    check("stream_level", 32'(fifo_level), 32'd2);
    run = 1'b1;
    for (int k = 1; k <= 19; k++) begin
      cyc(1);
      exp_dac = (k < 4) ? MID : stream_vals[(k - 4) / 4];
      check("stream_dac", 32'(DAC), 32'(exp_dac));
      check("stream_sel", 32'(DAC_SEL), (k < 4) ? 32'd1 : 32'(((k - 4) / 4) % 2));
      check("stream_dac_clk", 32'(DAC_CLK), 32'((k % 4) >= 2));
      check("stream_led1", 32'(LED1), 32'd0);
    end
    run = 1'b0;

    // ---------------- fill ----------------
    do_reset();
    in_valid = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      in_data = {8'(8'hA0 + i), 8'(i)};
      cyc(1);
    end
    in_data = {8'hA5, 8'h05};
    check("fill_level", 32'(fifo_level), 32'd4);
    check("fill_ready", 32'(in_ready), 32'd0);
    cyc(3);
    check("fill_hold_level", 32'(fifo_level), 32'd4);
    run = 1'b1;
    cyc(3);
    check("fill_prepop_level", 32'(fifo_level), 32'd4);
    cyc(1);
    check("fill_pop_level", 32'(fifo_level), 32'd3);
    check("fill_pop_ready", 32'(in_ready), 32'd1);
    check("fill_pop_dac", 32'(DAC), 32'h01);
    cyc(1);
    check("fill_fifth_level", 32'(fifo_level), 32'd4);
    check("fill_fifth_ready", 32'(in_ready), 32'd0);
    in_valid = 1'b0;
    run = 1'b0;

    // ---------------- underrun + mid-stream reset ----------------
    do_reset();
    in_valid = 1'b1;
    in_data  = {8'h22, 8'h11};
    cyc(1);
    in_valid = 1'b0;
    run = 1'b1;
    cyc(4);
    check("under_dac0", 32'(DAC), 32'h11);
    check("under_led0", 32'(LED1), 32'd0);
    cyc(4);
    check("under_dac1", 32'(DAC), 32'h22);
    check("under_led1", 32'(LED1), 32'd0);
    cyc(4);
    check("under_dac2", 32'(DAC), 32'h11);
    check("under_led2", 32'(LED1), 32'd1);
    cyc(4);
    check("under_dac3", 32'(DAC), 32'h22);
    cyc(3);
    underrun_clr = 1'b1;
    cyc(1);
    check("under_set_wins", 32'(LED1), 32'd1);
    check("under_repeat_dac", 32'(DAC), 32'h11);
    underrun_clr = 1'b0;
    in_valid = 1'b1;
    in_data  = {8'hEE, 8'hDD};
    cyc(1);
    in_valid = 1'b0;
    cyc(1);
    check("prereset_dac_clk", 32'(DAC_CLK), 32'd1);
    check("prereset_level", 32'(fifo_level), 32'd1);
    BUT1 = 1'b0;
    #1;
    check("rst_dac", 32'(DAC), 32'h80);
    check("rst_sel", 32'(DAC_SEL), 32'd1);
    check("rst_dac_clk", 32'(DAC_CLK), 32'd0);
    check("rst_led1", 32'(LED1), 32'd0);
    check("rst_level", 32'(fifo_level), 32'd0);
    check("rst_ready", 32'(in_ready), 32'd1);
    run = 1'b0;
    cyc(2);
    BUT1 = 1'b1;

    // ---------------- simultaneous push at frame boundary ----------------
    do_reset();
    run = 1'b1;
    cyc(3);
    in_valid = 1'b1;
    in_data  = {8'hA5, 8'h5A};
    cyc(1);
    in_valid = 1'b0;
    check("simul_led1", 32'(LED1), 32'd1);
    check("simul_level", 32'(fifo_level), 32'd1);
    check("simul_dac", 32'(DAC), 32'h80);
    check("simul_sel", 32'(DAC_SEL), 32'd0);
    underrun_clr = 1'b1;
    cyc(1);
    check("clear_led1", 32'(LED1), 32'd0);
    underrun_clr = 1'b0;
    cyc(3);
    check("simul_mid_dac", 32'(DAC), 32'h80);
    check("simul_mid_level", 32'(fifo_level), 32'd1);
    cyc(4);
    check("simul_next_dac", 32'(DAC), 32'h5A);
    check("simul_next_level", 32'(fifo_level), 32'd0);
    cyc(4);
    check("simul_next_ch1", 32'(DAC), 32'hA5);
    run = 1'b0;

    // ---------------- pause ----------------
    do_reset();
    in_valid = 1'b1;
    in_data  = {8'h77, 8'h66};
    cyc(1);
    in_valid = 1'b0;
    run = 1'b1;
    cyc(6);
    check("pause_pre_dac", 32'(DAC), 32'h66);
    check("pause_pre_clk", 32'(DAC_CLK), 32'd1);
    run = 1'b0;
    in_valid = 1'b1;
    in_data  = {8'h99, 8'h88};
    for (int k = 0; k < 10; k++) begin
      cyc(1);
      in_valid = 1'b0;
      check("pause_dac", 32'(DAC), 32'h66);
      check("pause_sel", 32'(DAC_SEL), 32'd0);
      check("pause_clk", 32'(DAC_CLK), 32'd1);
    end
    check("pause_push_level", 32'(fifo_level), 32'd1);
    run = 1'b1;
    cyc(1);
    check("resume_dac", 32'(DAC), 32'h66);
    check("resume_clk", 32'(DAC_CLK), 32'd1);
    cyc(1);
    check("resume_slot_dac", 32'(DAC), 32'h77);
    check("resume_slot_sel", 32'(DAC_SEL), 32'd1);
    check("resume_slot_clk", 32'(DAC_CLK), 32'd0);
    cyc(4);
    check("resume_frame_dac", 32'(DAC), 32'h88);
    check("resume_frame_level", 32'(fifo_level), 32'd0);
    run = 1'b0;
    cyc(2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/dac_stream_driver.md
DAC_STREAM_DRIVER -- requirements
Module: dac_stream_driver

Interface
REQ-001 SHALL have parameter WIDTH, default 8: DAC sample width in bits.
REQ-002 SHALL have parameter CHANNELS, default 2: channels per frame, time-multiplexed onto one DAC, >=1.
REQ-003 SHALL have parameter DEPTH, default 8: frame FIFO depth, power of two, >=2.
REQ-004 SHALL have parameter DIV, default 4: CLK cycles per DAC slot, even, >=2.
REQ-005 SHALL have port CLK  input  1  sole clock; all state on rising edge.
REQ-006 SHALL have port BUT1  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have port run  input  1  1 = slot timing advances, 0 = paused.
REQ-008 SHALL have port in_valid  input  1  frame offered.
REQ-009 SHALL have port in_ready  output  1  FIFO can accept a frame.
REQ-010 SHALL have port in_data  input  CHANNELS*WIDTH  frame; channel k in bits [k*WIDTH +: WIDTH].
REQ-011 SHALL have port underrun_clr  input  1  clears LED1.
REQ-012 SHALL have port DAC  output  WIDTH  registered DAC word.
REQ-013 SHALL have port DAC_CLK  output  1  registered DAC latch clock.
REQ-014 SHALL have port DAC_SEL  output  max(1,clog2(CHANNELS))  channel index of current DAC word.
REQ-015 SHALL have port LED1  output  1  sticky underrun flag.
REQ-016 SHALL have port fifo_level  output  clog2(DEPTH)+1  frames held in FIFO.

Function
REQ-017 SHALL push in_data into the FIFO on each edge where in_valid and in_ready are both 1; in_ready SHALL equal (fifo_level != DEPTH), registered-free from level.
REQ-018 SHALL keep in_ready 0 when full, including on a cycle where a pop occurs (no full-pass-through); fifo_level SHALL stay unchanged on a simultaneous push and pop.
REQ-019 SHALL run a divider div_cnt 0..DIV-1 that increments each edge while run=1 and holds while run=0; wrap DIV-1 -> 0 marks a slot boundary.
REQ-020 SHALL drive DAC_CLK = 1 exactly while div_cnt >= DIV/2 (registered so it is cycle-aligned with div_cnt), giving one rising DAC_CLK edge at mid-slot with DAC stable for DIV/2 cycles before it.
REQ-021 SHALL at each slot boundary advance DAC_SEL by 1, wrapping CHANNELS-1 -> 0, and load DAC with channel DAC_SEL(new) of the frame register on the same edge.
REQ-022 SHALL, when DAC_SEL wraps to 0 and the FIFO is non-empty, pop the oldest frame into the frame register on that edge and output its channel 0 on DAC at the same edge (pop data used directly, no extra latency).
REQ-023 SHALL, when DAC_SEL wraps to 0 and the FIFO is empty, leave the frame register unchanged (last frame repeats) and set LED1 on that edge.
REQ-024 SHALL not bypass a same-cycle push into a pop-attempt on an empty FIFO: the attempt is an underrun; the pushed frame is used at the next frame boundary.
REQ-025 SHALL clear LED1 when underrun_clr=1; set SHALL win over clear on the same edge.
REQ-026 SHALL, while run=0, hold DAC, DAC_SEL, frame register, LED1 and div_cnt; FIFO push continues.
REQ-027 SHALL compute fifo pointers modulo DEPTH, with fifo_level 0..DEPTH inclusive.

Reset
REQ-028 SHALL on BUT1=0 immediately force: div_cnt=0, DAC_CLK=0, DAC_SEL=CHANNELS-1, DAC=2^(WIDTH-1) (midscale), frame register all channels midscale, LED1=0, FIFO empty (fifo_level=0, in_ready=1).
REQ-029 SHALL discard FIFO contents and any partial slot when reset asserts mid-operation; first slot boundary after release pops (or underruns) with DAC_SEL=0.

Verification (WIDTH=8, CHANNELS=2, DEPTH=4, DIV=4)
REQ-030 SHALL test reset: BUT1 low mid-stream -> DAC=0x80, DAC_SEL=1, DAC_CLK=0, LED1=0, fifo_level=0 without a clock edge.
REQ-031 SHALL test streaming: push frames {ch0=0x10,ch1=0x20},{0x30,0x40}, run=1 -> DAC sequence 0x10,0x20,0x30,0x40 each held 4 cycles, DAC_SEL 0,1,0,1, DAC_CLK high cycles 2-3 of each slot, LED1=0.
REQ-032 SHALL test fill: run=0, push 5 frames with in_valid held -> 4 accepted, fifo_level=4, in_ready=0, 5th accepted only after the first pop.
REQ-033 SHALL test underrun: one frame {0x11,0x22} then no input -> DAC 0x11,0x22,0x11,0x22; LED1 set at the second frame boundary; underrun_clr while starved -> set wins, LED1 stays 1.
REQ-034 SHALL test simultaneous: push on the exact edge of a frame boundary with empty FIFO -> underrun flagged, fifo_level=1, frame used next boundary.
REQ-035 SHALL test pause: run dropped mid-slot for 10 cycles -> DAC, DAC_SEL, DAC_CLK frozen, slot resumes with remaining cycles unchanged.
